// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: access size
// codes, FSM state encoding, byte-enable base patterns and the W-stage bundle.
package mem_stage_lsu_pkg;

   // Access size, taken from funct3[1:0]; funct3[2] selects zero-extension
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // FSM state encoding
   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_WAIT_RSP = 1'b1;

   // Byte-enable patterns before lane shifting
   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   // MEM/WB pipeline register contents
   typedef struct packed {
      logic [31:0] readdata;
      logic [31:0] aluresult;
      logic [31:0] pcplus4;
      logic [4:0]  rd;
      logic        regwrite;
      logic        misalign;
      logic        buserr;
   } wb_t;

   // A bubble writes nothing and raises no flags
   function automatic wb_t wb_bubble();
      wb_t b;
      b = '0;
      return b;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Combinational lane logic: byte enables and replicated store data, load
// byte/half extraction with sign or zero extension, and misalignment detect.
module lsu_lane_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [31:0] shifted;
   logic        sign_en;

   // Bring the addressed byte/half down to bit 0
   assign shifted = load_word >> {addr_lo, 3'b000};
   assign sign_en = ~funct3[2];

   // Size decode drives every lane output together
   always_comb begin
      be        = BE_W;
      wdata     = store_data;
      load_data = load_word;
      misalign  = 1'b0;
      case (funct3[1:0])
         SZ_B: begin
            be        = BE_B << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{sign_en & shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            be        = BE_H << addr_lo;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{sign_en & shifted[15]}}, shifted[15:0]};
            misalign  = addr_lo[0];
         end
         default: begin
            // word (and unused size code 11) must be 4-byte aligned
            misalign = (addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues valid/ready data-memory requests,
// stalls the pipeline while a transaction is outstanding, aborts a load
// whose response never arrives, and registers the MEM/WB stage outputs.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        memreadm,
   input  logic        memwritem,
   input  logic        regwritem,
   input  logic [2:0]  funct3m,
   input  logic [31:0] aluresultm,
   input  logic [31:0] writedatam,
   input  logic [4:0]  rdm,
   input  logic [31:0] pcplus4m,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata,
   output logic        stallm,
   output logic [31:0] readdataw,
   output logic [31:0] aluresultw,
   output logic [31:0] pcplus4w,
   output logic [4:0]  rdw,
   output logic        regwritew,
   output logic        misalignw,
   output logic        buserrw
);

   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
   localparam logic       TO_EN  = (TIMEOUT != 0);

   logic [0:0]  state, state_d;
   logic [7:0]  cnt, cnt_d;
   wb_t         wb_q, wb_d;
   logic        memop, is_store, misalign_raw, misalign;
   logic        req_valid_c, stall_c;
   logic [31:0] ldata;

   // A load+store combination is handled as a store
   assign memop    = memreadm | memwritem;
   assign is_store = memwritem;
   assign misalign = memop & misalign_raw;

   lsu_lane_align u_align (
      .funct3     (funct3m),
      .addr_lo    (aluresultm[1:0]),
      .store_data (writedatam),
      .load_word  (dmem_rdata),
      .be         (dmem_be),
      .wdata      (dmem_wdata),
      .load_data  (ldata),
      .misalign   (misalign_raw)
   );

   // Request fields follow the held EX/MEM inputs, so they stay stable while stalled
   assign dmem_we        = is_store;
   assign dmem_addr      = {aluresultm[31:2], 2'b00};
   assign dmem_req_valid = req_valid_c & reset;
   assign stallm         = stall_c & reset;

   // Next-state, stall and W-stage value selection
   always_comb begin
      state_d          = state;
      cnt_d            = cnt;
      req_valid_c      = 1'b0;
      stall_c          = 1'b0;
      wb_d.readdata    = '0;
      wb_d.aluresult   = aluresultm;
      wb_d.pcplus4     = pcplus4m;
      wb_d.rd          = rdm;
      wb_d.regwrite    = regwritem & ~misalign;
      wb_d.misalign    = misalign;
      wb_d.buserr      = 1'b0;
      case (state)
         ST_IDLE: begin
            // misaligned accesses and non-memory ops pass straight through
            if (memop && !misalign) begin
               req_valid_c = 1'b1;
               if (is_store) begin
                  if (!dmem_req_ready) begin
                     stall_c = 1'b1;
                     wb_d    = wb_bubble();
                  end
               end else begin
                  stall_c = 1'b1;
                  wb_d    = wb_bubble();
                  if (dmem_req_ready) begin
                     state_d = ST_WAIT_RSP;
                     cnt_d   = '0;
                  end
               end
            end
         end
         ST_WAIT_RSP: begin
            // a response arriving on the abort cycle still wins
            if (dmem_rsp_valid) begin
               wb_d.readdata = ldata;
               state_d       = ST_IDLE;
            end else if (TO_EN && (cnt == TO_CNT)) begin
               wb_d.regwrite = 1'b0;
               wb_d.buserr   = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               stall_c = 1'b1;
               wb_d    = wb_bubble();
               if (cnt != 8'hFF) cnt_d = cnt + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM, timeout counter and MEM/WB register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         wb_q  <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         wb_q  <= wb_d;
      end
   end

   assign readdataw  = wb_q.readdata;
   assign aluresultw = wb_q.aluresult;
   assign pcplus4w   = wb_q.pcplus4;
   assign rdw        = wb_q.rd;
   assign regwritew  = wb_q.regwrite;
   assign misalignw  = wb_q.misalign;
   assign buserrw    = wb_q.buserr;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for reset behaviour.
module tb_mem_stage_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        memreadm, memwritem, regwritem;
   logic [2:0]  funct3m;
   logic [31:0] aluresultm, writedatam, pcplus4m;
   logic [4:0]  rdm;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;
   logic        stallm;
   logic [31:0] readdataw, aluresultw, pcplus4w;
   logic [4:0]  rdw;
   logic        regwritew, misalignw, buserrw;

   always #5 clk = ~clk;

   mem_stage_lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .memreadm(memreadm), .memwritem(memwritem), .regwritem(regwritem),
      .funct3m(funct3m), .aluresultm(aluresultm), .writedatam(writedatam),
      .rdm(rdm), .pcplus4m(pcplus4m),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .stallm(stallm), .readdataw(readdataw), .aluresultw(aluresultw),
      .pcplus4w(pcplus4w), .rdw(rdw), .regwritew(regwritew),
      .misalignw(misalignw), .buserrw(buserrw)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ld, st, rw;
      logic [2:0]  f3;
      logic [31:0] a, wd, rdata;
      logic [4:0]  rdm;
      int          rdy, rsp;
   } op_t;

   typedef struct {
      logic        req;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          stalls;
      logic [31:0] rdw;
      logic        mis, rw, berr;
   } exp_t;

   typedef struct {
      op_t  op;
      exp_t e;
   } vec_t;

   function automatic op_t mk_op(input logic ld, st, rw, input logic [2:0] f3,
                                 input logic [31:0] a, wd, rdata, input logic [4:0] rd,
                                 input int rdy, rsp);
      op_t o;
      o.ld = ld; o.st = st; o.rw = rw; o.f3 = f3; o.a = a; o.wd = wd;
      o.rdata = rdata; o.rdm = rd; o.rdy = rdy; o.rsp = rsp;
      return o;
   endfunction

   function automatic exp_t mk_exp(input logic req, input logic [3:0] be,
                                   input logic [31:0] wdata, input int stalls,
                                   input logic [31:0] rdw, input logic mis, rw, berr);
      exp_t e;
      e.req = req; e.be = be; e.wdata = wdata; e.stalls = stalls;
      e.rdw = rdw; e.mis = mis; e.rw = rw; e.berr = berr;
      return e;
   endfunction

   // Reference model: access size in bytes, byte offset, masks and shifts
   function automatic exp_t model(input op_t o);
      exp_t e;
      int sz, off;
      longint unsigned mask, v;
      bit memop, load;
      memop = o.ld || o.st;
      sz    = (o.f3[1:0] == 2'b00) ? 1 : (o.f3[1:0] == 2'b01) ? 2 : 4;
      off   = int'(o.a & 32'h3);
      e.mis = memop && ((off % sz) != 0);
      e.req = memop && !e.mis;
      e.be  = (sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << off);
      if (sz == 1)      e.wdata = (o.wd & 32'hFF) * 32'h01010101;
      else if (sz == 2) e.wdata = (o.wd & 32'hFFFF) * 32'h00010001;
      else              e.wdata = o.wd;
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v    = ({32'd0, o.rdata} >> (8 * off)) & mask;
      if (!o.f3[2] && sz < 4 && ((v >> (8 * sz - 1)) & 64'd1) != 0) v = v | ~mask;
      load     = o.ld && !o.st && !e.mis;
      e.stalls = !e.req ? 0 : (o.st ? o.rdy : o.rdy + 1 + o.rsp);
      e.rdw    = load ? v[31:0] : 32'd0;
      e.rw     = o.rw && !e.mis;
      e.berr   = 1'b0;
      return e;
   endfunction

   // Apply one M-stage instruction, holding it while stalled; entered just after a posedge
   task automatic run_op(input op_t o, input exp_t e);
      int          hs, stalls;
      bit          seen, done, stall_now;
      logic [31:0] s_addr, s_wdata;
      logic [3:0]  s_be;
      logic        s_we;
      memreadm = o.ld; memwritem = o.st; regwritem = o.rw; funct3m = o.f3;
      aluresultm = o.a; writedatam = o.wd; rdm = o.rdm; pcplus4m = o.a + 32'h4000;
      dmem_rdata = o.rdata;
      hs = -1; stalls = 0; seen = 0; done = 0;
      s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         dmem_req_ready = (k >= o.rdy);
         dmem_rsp_valid = (hs >= 0) && (k == hs + 1 + o.rsp);
         @(negedge clk);
         if (dmem_req_valid) begin
            if (!seen) begin
               seen = 1; s_addr = dmem_addr; s_wdata = dmem_wdata; s_be = dmem_be; s_we = dmem_we;
            end else begin
               chk("req_stable_addr", dmem_addr, s_addr);
               chk("req_stable_be", {28'd0, dmem_be}, {28'd0, s_be});
               chk("req_stable_wdata", dmem_wdata, s_wdata);
               chk("req_stable_we", {31'd0, dmem_we}, {31'd0, s_we});
            end
            if (dmem_req_ready) hs = k;
         end
         stall_now = stallm;
         @(posedge clk); #1;
         if (stall_now) begin
            stalls++;
            chk("bubble_regwritew", {31'd0, regwritew}, 32'd0);
            chk("bubble_rdw", {27'd0, rdw}, 32'd0);
            chk("bubble_flags", {30'd0, misalignw, buserrw}, 32'd0);
         end else begin
            done = 1;
         end
      end
      chk("op_completes", {31'd0, done}, 32'd1);
      chk("req_issued", {31'd0, seen}, {31'd0, e.req});
      if (e.req && seen) begin
         chk("dmem_addr", s_addr, {o.a[31:2], 2'b00});
         chk("dmem_be", {28'd0, s_be}, {28'd0, e.be});
         chk("dmem_we", {31'd0, s_we}, {31'd0, o.st});
         if (o.st) chk("dmem_wdata", s_wdata, e.wdata);
      end
      chk("stall_cycles", stalls, e.stalls);
      chk("readdataw", readdataw, e.rdw);
      chk("regwritew", {31'd0, regwritew}, {31'd0, e.rw});
      chk("misalignw", {31'd0, misalignw}, {31'd0, e.mis});
      chk("buserrw", {31'd0, buserrw}, {31'd0, e.berr});
      if (!e.berr) begin
         chk("rdw", {27'd0, rdw}, {27'd0, o.rdm});
         chk("aluresultw", aluresultw, o.a);
         chk("pcplus4w", pcplus4w, o.a + 32'h4000);
      end
      memreadm = 1'b0; memwritem = 1'b0; regwritem = 1'b0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
   endtask

   vec_t tbl[16];
   logic [2:0] f3s[5];

   initial begin
      tbl[0]  = '{mk_op(0,1,0,3'b010,32'h100,32'hDEADBEEF,32'h0,5'd0,0,0),      mk_exp(1,4'hF,32'hDEADBEEF,0,32'h0,0,0,0)};
      tbl[1]  = '{mk_op(1,0,1,3'b000,32'h103,32'h0,32'h80FFFF7F,5'd5,0,0),      mk_exp(1,4'h8,32'h0,1,32'hFFFFFF80,0,1,0)};
      tbl[2]  = '{mk_op(1,0,1,3'b101,32'h102,32'h0,32'h80010000,5'd6,3,0),      mk_exp(1,4'hC,32'h0,4,32'h00008001,0,1,0)};
      tbl[3]  = '{mk_op(1,0,1,3'b010,32'h101,32'h0,32'h12345678,5'd7,0,0),      mk_exp(0,4'h0,32'h0,0,32'h0,1,0,0)};
      tbl[4]  = '{mk_op(0,1,0,3'b000,32'h101,32'h123456AB,32'h0,5'd0,2,0),      mk_exp(1,4'h2,32'hABABABAB,2,32'h0,0,0,0)};
      tbl[5]  = '{mk_op(0,1,0,3'b001,32'h102,32'hFFFF1234,32'h0,5'd3,0,0),      mk_exp(1,4'hC,32'h12341234,0,32'h0,0,0,0)};
      tbl[6]  = '{mk_op(1,0,1,3'b001,32'h100,32'h0,32'h12348765,5'd8,1,2),      mk_exp(1,4'h3,32'h0,4,32'hFFFF8765,0,1,0)};
      tbl[7]  = '{mk_op(1,0,1,3'b100,32'h102,32'h0,32'h11F022EE,5'd9,0,1),      mk_exp(1,4'h4,32'h0,2,32'h000000F0,0,1,0)};
      tbl[8]  = '{mk_op(1,0,1,3'b010,32'h104,32'h0,32'hCAFEF00D,5'd10,0,3),     mk_exp(1,4'hF,32'h0,4,32'hCAFEF00D,0,1,0)};
      tbl[9]  = '{mk_op(0,1,0,3'b001,32'h103,32'hAAAA5555,32'h0,5'd0,0,0),      mk_exp(0,4'h0,32'h0,0,32'h0,1,0,0)};
      tbl[10] = '{mk_op(0,0,1,3'b000,32'h55,32'h0,32'hFFFFFFFF,5'd7,0,0),       mk_exp(0,4'h0,32'h0,0,32'h0,0,1,0)};
      tbl[11] = '{mk_op(1,1,0,3'b010,32'h108,32'h01020304,32'h99999999,5'd0,0,0), mk_exp(1,4'hF,32'h01020304,0,32'h0,0,0,0)};
      tbl[12] = '{mk_op(1,0,1,3'b010,32'h200,32'h0,32'hFFFFFFFF,5'd11,0,99),    mk_exp(1,4'hF,32'h0,5,32'h0,0,0,1)};
      tbl[13] = '{mk_op(1,0,1,3'b000,32'h100,32'h0,32'h0000007F,5'd12,0,0),     mk_exp(1,4'h1,32'h0,1,32'h0000007F,0,1,0)};
      tbl[14] = '{mk_op(1,0,1,3'b001,32'h102,32'h0,32'h7FFF0000,5'd13,2,1),     mk_exp(1,4'hC,32'h0,4,32'h00007FFF,0,1,0)};
      tbl[15] = '{mk_op(1,0,1,3'b101,32'h100,32'h0,32'h0000FFFF,5'd14,0,0),     mk_exp(1,4'h3,32'h0,1,32'h0000FFFF,0,1,0)};
      f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;

      // Reset state, with a store presented to confirm request gating
      reset = 1'b0;
      memreadm = 1'b0; memwritem = 1'b1; regwritem = 1'b1; funct3m = 3'b010;
      aluresultm = 32'h100; writedatam = 32'h1; rdm = 5'd3; pcplus4m = 32'h8;
      dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
      #12;
      chk("reset_req_valid", {31'd0, dmem_req_valid}, 32'd0);
      chk("reset_stallm", {31'd0, stallm}, 32'd0);
      chk("reset_w_data", readdataw | aluresultw | pcplus4w, 32'd0);
      chk("reset_w_ctrl", {24'd0, rdw, regwritew, misalignw, buserrw}, 32'd0);
      memwritem = 1'b0; regwritem = 1'b0; dmem_req_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;

      // Directed table
      for (int i = 0; i < 16; i++) run_op(tbl[i].op, tbl[i].e);

      // Randomized ops against the reference model
      for (int i = 0; i < 150; i++) begin
         op_t o;
         int  kind;
         kind    = $urandom_range(0, 3);
         o.ld    = (kind == 1) || (kind == 3);
         o.st    = (kind == 2) || (kind == 3);
         o.rw    = 1'($urandom_range(0, 1));
         o.f3    = f3s[$urandom_range(0, 4)];
         o.a     = $urandom;
         o.wd    = $urandom;
         o.rdata = $urandom;
         o.rdm   = 5'($urandom_range(0, 31));
         o.rdy   = $urandom_range(0, 3);
         o.rsp   = $urandom_range(0, 3);
         run_op(o, model(o));
      end

      // Reset while a load waits for its response
      memreadm = 1'b0; memwritem = 1'b0; regwritem = 1'b1; rdm = 5'd9;
      aluresultm = 32'h1234; pcplus4m = 32'h5678;
      @(posedge clk); #1;
      chk("pre_reset_rdw", {27'd0, rdw}, 32'd9);
      memreadm = 1'b1; regwritem = 1'b1; funct3m = 3'b010; aluresultm = 32'h300;
      dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      @(posedge clk); #1;
      chk("wait_rsp_stall", {31'd0, stallm}, 32'd1);
      chk("wait_rsp_no_req", {31'd0, dmem_req_valid}, 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("midrst_stallm", {31'd0, stallm}, 32'd0);
      chk("midrst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
      chk("midrst_w_data", readdataw | aluresultw | pcplus4w, 32'd0);
      chk("midrst_w_ctrl", {24'd0, rdw, regwritew, misalignw, buserrw}, 32'd0);
      memreadm = 1'b0; regwritem = 1'b0; rdm = 5'd0;
      @(posedge clk); #1;
      reset = 1'b1;
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("late_rsp_stallm", {31'd0, stallm}, 32'd0);
      @(posedge clk); #1;
      chk("late_rsp_readdataw", readdataw, 32'd0);
      chk("late_rsp_buserrw", {31'd0, buserrw}, 32'd0);
      dmem_rsp_valid = 1'b0;
      run_op(mk_op(1,0,1,3'b000,32'h101,32'h0,32'h00008000,5'd4,0,0),
             mk_exp(1,4'h2,32'h0,1,32'hFFFFFF80,0,1,0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
